// File: rtl/random_delay_pkg.sv
// Shared types and default parameters for the random_delay block.
package random_delay_pkg;
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    localparam int WIDTH_DEF     = 7;
    localparam int TICK_DIV_DEF  = 48000;
    localparam int MIN_DELAY_DEF = 1;
endpackage

// File: rtl/random_delay_tick_prescaler.sv
// Mod-TICK_DIV cycle counter; tick is a combinational pulse on the terminal count.
module tick_prescaler #(
    parameter int TICK_DIV = random_delay_pkg::TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/random_delay.sv
// Captures an LFSR value as a tick delay, counts it down, then pulses time_out.
// Define RANDOM_DELAY_RETRIGGER_EN to let trigger restart a delay already in COUNT.
module random_delay
    import random_delay_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int MIN_DELAY = MIN_DELAY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger,
    input  logic [WIDTH-1:0] rnd,
    output logic             lfsr_en,
    output logic             busy,
    output logic             time_out,
    output logic [WIDTH-1:0] remaining
);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_DELAY);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             lfsr_en_q, lfsr_en_d;
    logic             capture, tick;
    logic [WIDTH-1:0] clamped;

    assign clamped = (rnd < MIN_W) ? MIN_W : rnd;

`ifdef RANDOM_DELAY_RETRIGGER_EN
    assign capture = trigger && (state_q == IDLE || state_q == COUNT);
`else
    assign capture = trigger && (state_q == IDLE);
`endif

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (capture),
        .en    (state_q == COUNT),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        lfsr_en_d = 1'b0;
        if (capture) begin
            // a recapture in COUNT takes priority over a coincident tick
            rem_d     = clamped;
            lfsr_en_d = 1'b1;
            state_d   = COUNT;
        end else begin
            case (state_q)
                COUNT: begin
                    if (tick) begin
                        if (rem_q <= WIDTH'(1)) begin
                            rem_d   = '0;
                            state_d = DONE;
                        end else begin
                            rem_d = rem_q - 1'b1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            lfsr_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            lfsr_en_q <= lfsr_en_d;
        end
    end

    assign busy      = (state_q == COUNT) || (state_q == DONE);
    assign time_out  = (state_q == DONE);
    assign remaining = rem_q;
    assign lfsr_en   = lfsr_en_q;
endmodule

// File: tb/tb_random_delay.sv
// Directed bench: two instances (TICK_DIV 4 and 2); expected time_out cycles are queued at trigger time.
module tb_random_delay;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic t4 = 1'b0, t2 = 1'b0;
    logic [6:0] r4 = '0, r2 = '0;
    logic le4, bz4, to4, le2, bz2, to2;
    logic [6:0] rem4, rem2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int le_cnt4 = 0, to_cnt4 = 0;
    int q4[$];
    int q2[$];
    int prev_rem2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    random_delay #(.WIDTH(7), .TICK_DIV(4), .MIN_DELAY(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .trigger(t4), .rnd(r4),
        .lfsr_en(le4), .busy(bz4), .time_out(to4), .remaining(rem4));

    random_delay #(.WIDTH(7), .TICK_DIV(2), .MIN_DELAY(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .trigger(t2), .rnd(r2),
        .lfsr_en(le2), .busy(bz2), .time_out(to2), .remaining(rem2));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every time_out must match the head of its queue.
    always @(negedge clk) begin
        if (to4) begin
            to_cnt4++;
            chk("to4_expected", int'(q4.size() > 0), 1);
            if (q4.size() > 0) chk("to4_cycle", cyc, q4.pop_front());
        end
        if (le4) le_cnt4++;
        if (to2) begin
            chk("to2_expected", int'(q2.size() > 0), 1);
            if (q2.size() > 0) chk("to2_cycle", cyc, q2.pop_front());
        end
        if (bz2 && !le2 && rst_n) begin
            checks++;
            assert (int'(rem2) <= prev_rem2) else begin
                errors++;
                $error("FAIL rem2_monotonic observed=%0d expected<=%0d", rem2, prev_rem2);
            end
        end
        prev_rem2 = int'(rem2);
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pulse trigger on dut4 for one edge; returns that edge (E0).
    task automatic pulse4(input logic [6:0] v, output int e0);
        @(negedge clk);
        r4 = v; t4 = 1'b1; e0 = cyc + 1;
        @(negedge clk);
        t4 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, l0, c0;
        // reset state
        #12;
        chk("rst_busy", bz4, 0); chk("rst_to", to4, 0);
        chk("rst_le", le4, 0);   chk("rst_rem", rem4, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // rnd=5: capture, countdown at 4-cycle steps, time_out at E0+20
        l0 = le_cnt4;
        @(negedge clk);
        r4 = 7'd5; t4 = 1'b1; e0 = cyc + 1; q4.push_back(e0 + 20);
        @(negedge clk);
        t4 = 1'b0; r4 = 7'd9;
        chk("t1_le_e0", le4, 1); chk("t1_rem_e0", rem4, 5); chk("t1_busy", bz4, 1);
        wait_cyc(e0 + 1); chk("t1_le_e1", le4, 0);
        for (int k = 1; k <= 5; k++) begin
            wait_cyc(e0 + 4 * k);
            chk("t1_rem_step", rem4, 5 - k);
        end
        chk("t1_to_e20", to4, 1);
        wait_cyc(e0 + 21);
        chk("t1_busy_after", bz4, 0); chk("t1_to_after", to4, 0);
        chk("t1_q_drained", q4.size(), 0); chk("t1_le_count", le_cnt4 - l0, 1);

        // rnd=0 clamps to 1 tick
        @(negedge clk);
        r4 = 7'd0; t4 = 1'b1; e0 = cyc + 1; q4.push_back(e0 + 4);
        @(negedge clk); t4 = 1'b0;
        chk("t2_rem_clamp", rem4, 1);
        wait_cyc(e0 + 5);
        chk("t2_q_drained", q4.size(), 0); chk("t2_busy", bz4, 0);

        // rnd=127 with TICK_DIV=2
        @(negedge clk);
        r2 = 7'd127; t2 = 1'b1; e0 = cyc + 1; q2.push_back(e0 + 254);
        @(negedge clk); t2 = 1'b0; r2 = 7'd3;
        chk("t3_rem_e0", rem2, 127);
        wait_cyc(e0 + 255);
        chk("t3_q_drained", q2.size(), 0); chk("t3_busy", bz2, 0); chk("t3_rem", rem2, 0);

`ifndef RANDOM_DELAY_RETRIGGER_EN
        // triggers during COUNT are ignored
        l0 = le_cnt4;
        @(negedge clk);
        r4 = 7'd5; t4 = 1'b1; e0 = cyc + 1; q4.push_back(e0 + 20);
        @(negedge clk); t4 = 1'b0;
        wait_cyc(e0 + 2); t4 = 1'b1; r4 = 7'd1;
        @(negedge clk); t4 = 1'b0;
        wait_cyc(e0 + 8); t4 = 1'b1;
        @(negedge clk); t4 = 1'b0;
        wait_cyc(e0 + 12); chk("t4_rem_e12", rem4, 2);
        wait_cyc(e0 + 21);
        chk("t4_q_drained", q4.size(), 0); chk("t4_le_count", le_cnt4 - l0, 1);
`endif

        // asynchronous reset mid-COUNT
        pulse4(7'd5, e0);
        q4.push_back(e0 + 20);
        wait_cyc(e0 + 9);
        #2 rst_n = 1'b0;
        q4.delete();
        #1;
        chk("t5_busy", bz4, 0); chk("t5_rem", rem4, 0);
        chk("t5_to", to4, 0);   chk("t5_le", le4, 0);
        l0 = to_cnt4; c0 = le_cnt4;
        @(negedge clk); rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("t5_no_to", to_cnt4 - l0, 0); chk("t5_no_le", le_cnt4 - c0, 0);
        pulse4(7'd3, e0);
        q4.push_back(e0 + 12);
        chk("t5_rem_new", rem4, 3);
        wait_cyc(e0 + 13);
        chk("t5_q_drained", q4.size(), 0);

        // trigger held high, rnd=2
        l0 = le_cnt4;
        @(negedge clk);
        r4 = 7'd2; t4 = 1'b1; e0 = cyc + 1;
`ifndef RANDOM_DELAY_RETRIGGER_EN
        q4.push_back(e0 + 8); q4.push_back(e0 + 18); q4.push_back(e0 + 28);
        wait_cyc(e0 + 28);
        t4 = 1'b0;
        wait_cyc(e0 + 30);
        chk("t6_q_drained", q4.size(), 0); chk("t6_le_count", le_cnt4 - l0, 3);
        chk("t6_busy", bz4, 0);
`else
        c0 = to_cnt4;
        wait_cyc(e0 + 30);
        chk("t6_no_to", to_cnt4 - c0, 0); chk("t6_le_held", le4, 1);
        chk("t6_rem_held", rem4, 2);
        t4 = 1'b0; q4.push_back(e0 + 30 + 8);
        wait_cyc(e0 + 39);
        chk("t6_q_drained", q4.size(), 0);
`endif

        chk("end_q4_empty", q4.size(), 0);
        chk("end_q2_empty", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
